// File: rtl/particle_pkg.sv
// Shared definitions for the particle renderer: frame-buffer size,
// coordinate type, FSM state encoding and an on-grid helper.
package particle_pkg;

   localparam int FB_DIM = 16;

   typedef logic signed [31:0] coord_t;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      CLEAR,
      PLOT,
      WAIT_VS,
      SWAP
   } state_t;

   // True when a coordinate lands inside 0..FB_DIM-1 (signed compare).
   function automatic logic on_grid(input coord_t c);
      return (c >= 0) && (c < FB_DIM);
   endfunction

endpackage

// File: rtl/particle_row_scan.sv
// Display row scanner: holds each row for SCAN_DIV cycles, wraps 15->0,
// and flags the very last cycle of row 15 (vsync) so the renderer can
// swap buffers exactly as the scan returns to row 0.
module particle_row_scan
   import particle_pkg::*;
#(
   parameter int SCAN_DIV = 1024
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] row_sel,
   output logic [3:0] row_next,
   output logic       vsync
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_reg;
   logic [3:0]       row_reg;
   logic             terminal;

   assign terminal = (div_reg == DIV_W'(SCAN_DIV - 1));
   assign row_next = terminal ? row_reg + 4'd1 : row_reg;
   assign vsync    = terminal && (row_reg == 4'(FB_DIM - 1));
   assign row_sel  = row_reg;

   // Free-running divider and row counter, never gated by the renderer.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg <= '0;
         row_reg <= '0;
      end else begin
         div_reg <= terminal ? '0 : div_reg + 1'b1;
         row_reg <= row_next;
      end
   end

endmodule

// File: rtl/particle_render.sv
// Double-buffered 16x16 particle renderer. A frame request captures the
// four particle positions, clears the back buffer, plots one particle per
// cycle, then waits for the end of the scan to copy back->front.
// Optional feature macro: PARTICLE_TRAIL_EN (clear loads back from front,
// fully zeroing only on every 8th frame).
module particle_render
   import particle_pkg::*;
#(
   parameter int NUM_P    = 4,
   parameter int SCAN_DIV = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_req,
   input  coord_t      x0,
   input  coord_t      x1,
   input  coord_t      x2,
   input  coord_t      x3,
   input  coord_t      y0,
   input  coord_t      y1,
   input  coord_t      y2,
   input  coord_t      y3,
   output logic [3:0]  row_sel,
   output logic [15:0] col_data,
   output logic        busy,
   output logic        frame_done,
   output logic [2:0]  clip_cnt
);

   localparam logic [2:0] LAST_P = 3'(NUM_P - 1);

   state_t      state_reg, state_next;
   coord_t      cap_x [0:3];
   coord_t      cap_y [0:3];
   logic [15:0] back_reg  [0:FB_DIM-1];
   logic [15:0] front_reg [0:FB_DIM-1];
   logic [15:0] col_data_reg;
   logic [2:0]  pidx_reg;
   logic [2:0]  clip_acc_reg;
   logic [2:0]  clip_cnt_reg;
   logic [3:0]  row_next;
   logic        vsync;
`ifdef PARTICLE_TRAIL_EN
   logic [2:0]  frame_cnt_reg;
`endif

   coord_t      px, py;
   logic        p_hit;
   logic [3:0]  p_row, p_col;

   particle_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk      (clk),
      .reset    (reset),
      .row_sel  (row_sel),
      .row_next (row_next),
      .vsync    (vsync)
   );

   // Particle being plotted this cycle; y is flipped so positive y is up.
   assign px    = cap_x[pidx_reg[1:0]];
   assign py    = cap_y[pidx_reg[1:0]];
   assign p_hit = on_grid(px) && on_grid(py);
   assign p_row = 4'(FB_DIM - 1) - py[3:0];
   assign p_col = px[3:0];

   assign col_data = col_data_reg;
   assign clip_cnt = clip_cnt_reg;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // FSM next-state and status outputs; requests outside IDLE are dropped.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (frame_req) state_next = CAPTURE;
         end
         CAPTURE: state_next = CLEAR;
         CLEAR:   state_next = PLOT;
         PLOT:    if (pidx_reg == LAST_P) state_next = WAIT_VS;
         WAIT_VS: if (vsync) state_next = SWAP;
         SWAP: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // Snapshot of particle positions so later input changes cannot leak in.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            cap_x[i] <= '0;
            cap_y[i] <= '0;
         end
      end else if (state_reg == CAPTURE) begin
         cap_x[0] <= x0;  cap_y[0] <= y0;
         cap_x[1] <= x1;  cap_y[1] <= y1;
         cap_x[2] <= x2;  cap_y[2] <= y2;
         cap_x[3] <= x3;  cap_y[3] <= y3;
      end
   end

   // Back buffer drawing: one-cycle clear, then one particle per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < FB_DIM; r++) back_reg[r] <= '0;
         pidx_reg     <= '0;
         clip_acc_reg <= '0;
      end else begin
         case (state_reg)
            CLEAR: begin
               pidx_reg     <= '0;
               clip_acc_reg <= '0;
               for (int r = 0; r < FB_DIM; r++) begin
`ifdef PARTICLE_TRAIL_EN
                  back_reg[r] <= (frame_cnt_reg == 3'd7) ? 16'h0000 : front_reg[r];
`else
                  back_reg[r] <= 16'h0000;
`endif
               end
            end
            PLOT: begin
               pidx_reg <= pidx_reg + 3'd1;
               if (p_hit) back_reg[p_row][p_col] <= 1'b1;
               else       clip_acc_reg <= clip_acc_reg + 3'd1;
            end
            default: ;
         endcase
      end
   end

   // Presentation side: buffer swap, clip count and frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < FB_DIM; r++) front_reg[r] <= '0;
         clip_cnt_reg <= '0;
`ifdef PARTICLE_TRAIL_EN
         frame_cnt_reg <= '0;
`endif
      end else if (state_reg == SWAP) begin
         for (int r = 0; r < FB_DIM; r++) front_reg[r] <= back_reg[r];
         clip_cnt_reg <= clip_acc_reg;
`ifdef PARTICLE_TRAIL_EN
         frame_cnt_reg <= frame_cnt_reg + 3'd1;
`endif
      end
   end

   // Column register tracks next cycle's front row so it always matches
   // row_sel, including the cycle right after a swap.
   always_ff @(posedge clk) begin
      if (reset)                   col_data_reg <= '0;
      else if (state_reg == SWAP)  col_data_reg <= back_reg[row_next];
      else                         col_data_reg <= front_reg[row_next];
   end

endmodule

// File: tb/tb_particle_render.sv
// Bench for particle_render: a frame-level model (scan time, frame age,
// rendered image) checked against the DUT every cycle, plus directed
// frames with hand-computed pixel values.
module tb_particle_render;
   import particle_pkg::*;

   localparam int NUM_P    = 4;
   localparam int SCAN_DIV = 4;
   localparam int FRAME_T  = 16 * SCAN_DIV;
`ifdef PARTICLE_TRAIL_EN
   localparam bit TRAIL = 1'b1;
`else
   localparam bit TRAIL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_req = 1'b0;
   coord_t      x0, x1, x2, x3, y0, y1, y2, y3;
   logic [3:0]  row_sel;
   logic [15:0] col_data;
   logic        busy, frame_done;
   logic [2:0]  clip_cnt;

   always #5 clk = ~clk;

   particle_render #(.NUM_P(NUM_P), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .reset(reset), .frame_req(frame_req),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .row_sel(row_sel), .col_data(col_data), .busy(busy),
      .frame_done(frame_done), .clip_cnt(clip_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [15:0] m_front [16];
   logic [15:0] m_pend  [16];
   int  m_scan, m_age, m_clip, m_pend_clip, m_cnt;
   bit  m_busy, m_swap, m_valid = 1'b0;

   // Advance the model by one clock: scan time, frame age, swap decision.
   always @(posedge clk) begin
      int old_scan;
      coord_t px [4];
      coord_t py [4];
      if (reset) begin
         m_valid = 1'b1;
         m_scan = 0; m_age = 0; m_clip = 0; m_cnt = 0;
         m_busy = 1'b0; m_swap = 1'b0;
         for (int r = 0; r < 16; r++) m_front[r] = 16'h0;
      end else begin
         old_scan = m_scan;
         m_scan = (m_scan + 1) % FRAME_T;
         if (m_swap) begin
            for (int r = 0; r < 16; r++) m_front[r] = m_pend[r];
            m_clip = m_pend_clip;
            m_cnt  = (m_cnt + 1) % 8;
            m_busy = 1'b0;
            m_swap = 1'b0;
         end else if (m_busy) begin
            if (m_age == 0) begin
               px = '{x0, x1, x2, x3};
               py = '{y0, y1, y2, y3};
               for (int r = 0; r < 16; r++)
                  m_pend[r] = (TRAIL && m_cnt != 7) ? m_front[r] : 16'h0;
               m_pend_clip = 0;
               for (int i = 0; i < NUM_P; i++) begin
                  if (px[i] >= 0 && px[i] <= 15 && py[i] >= 0 && py[i] <= 15)
                     m_pend[15 - py[i]][px[i]] = 1'b1;
                  else
                     m_pend_clip++;
               end
            end
            // capture, clear and NUM_P plot cycles precede the vsync wait
            if (m_age >= 2 + NUM_P && old_scan == FRAME_T - 1) m_swap = 1'b1;
            else m_age++;
         end else if (frame_req) begin
            m_busy = 1'b1;
            m_age  = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      int exp_row;
      if (m_valid) begin
         exp_row = m_scan / SCAN_DIV;
         check("row_sel", 32'(row_sel), 32'(exp_row));
         check("col_data", 32'(col_data), 32'(m_front[exp_row]));
         check("busy", 32'(busy), 32'(m_busy));
         check("frame_done", 32'(frame_done), 32'(m_swap));
         check("clip_cnt", 32'(clip_cnt), 32'(m_clip));
         if (frame_done === 1'b1) done_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic set_pts(input coord_t ax, input coord_t ay, input coord_t bx, input coord_t by,
                          input coord_t cx, input coord_t cy, input coord_t dx, input coord_t dy);
      x0 = ax; y0 = ay; x1 = bx; y1 = by; x2 = cx; y2 = cy; x3 = dx; y3 = dy;
   endtask

   task automatic pulse_req();
      @(negedge clk); frame_req = 1'b1;
      @(negedge clk); frame_req = 1'b0;
   endtask

   task automatic wait_done(output logic [3:0] prev_row);
      logic [3:0] last;
      last = row_sel;
      prev_row = 4'hx;
      for (int i = 0; i < 3 * FRAME_T; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            prev_row = last;
            $display("frame_done at %0t row_sel=%0d prev_row=%0d", $time, row_sel, last);
            return;
         end
         last = row_sel;
      end
      check("frame_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_row(input logic [3:0] r);
      for (int i = 0; i < FRAME_T + 4; i++) begin
         @(negedge clk);
         if (row_sel == r) return;
      end
      check("row_wait_timeout", 32'(row_sel), 32'(r));
   endtask

   task automatic run_frame();
      logic [3:0] pr;
      pulse_req();
      wait_done(pr);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [3:0] pr;
      int base;
      set_pts(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      check("rst_row", 32'(row_sel), 32'd0);
      check("rst_col", 32'(col_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_clip", 32'(clip_cnt), 32'd0);

      // single (coincident) particle at (3,0) -> bottom row, column 3
      set_pts(3, 0, 3, 0, 3, 0, 3, 0);
      pulse_req();
      wait_done(pr);
      check("t1_swap_row", 32'(row_sel), 32'd0);
      wait_row(4'd15);
      check("t1_row15", 32'(col_data), 32'h0008);
      check("t1_model_row15", 32'(m_front[15]), 32'h0008);
      check("t1_clip", 32'(clip_cnt), 32'd0);

      // corners plus one off-grid particle
      do_reset();
      set_pts(0, 15, 15, 0, 15, 0, 20, 2);
      pulse_req();
      wait_done(pr);
      @(negedge clk);
      check("t2_clip", 32'(clip_cnt), 32'd1);
      check("t2_row0", 32'(col_data), 32'h0001);
      check("t2_busy_after", 32'(busy), 32'd0);
      wait_row(4'd15);
      check("t2_row15", 32'(col_data), 32'h8000);

      // repeated requests while busy, inputs changed after capture
      do_reset();
      set_pts(5, 5, 5, 5, 5, 5, 5, 5);
      base = done_cnt;
      pulse_req();
      @(negedge clk);
      set_pts(9, 9, 9, 9, 9, 9, 9, 9);
      for (int i = 0; i < 5; i++) begin
         check("t3_busy", 32'(busy), 32'd1);
         pulse_req();
      end
      wait_done(pr);
      wait_row(4'd10);
      check("t3_row10", 32'(col_data), 32'h0020);
      check("t3_model_row10", 32'(m_front[10]), 32'h0020);
      repeat (2 * FRAME_T) @(negedge clk);
      check("t3_one_done", 32'(done_cnt - base), 32'd1);

      // request mid-scan: swap lands exactly on the 15->0 wrap
      do_reset();
      set_pts(2, 15, 2, 15, 2, 15, 2, 15);
      wait_row(4'd3);
      pulse_req();
      wait_done(pr);
      check("t4_prev_row", 32'(pr), 32'd15);
      check("t4_swap_row", 32'(row_sel), 32'd0);
      @(negedge clk);
      check("t4_row0", 32'(col_data), 32'h0004);

      // reset during PLOT abandons the frame
      base = done_cnt;
      set_pts(6, 6, 6, 6, 6, 6, 6, 6);
      pulse_req();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_col", 32'(col_data), 32'd0);
      check("t5_done", 32'(frame_done), 32'd0);
      repeat (3 * FRAME_T) @(negedge clk);
      check("t5_no_done", 32'(done_cnt - base), 32'd0);

      // moving particle over two frames, then six more frames to the 8th
      do_reset();
      set_pts(0, 0, 0, 0, 0, 0, 0, 0);
      run_frame();
      set_pts(1, 0, 1, 0, 1, 0, 1, 0);
      run_frame();
      wait_row(4'd15);
      check("t6_frame2_row15", 32'(col_data), TRAIL ? 32'h0003 : 32'h0002);
      for (int f = 3; f <= 8; f++) run_frame();
      wait_row(4'd15);
      check("t6_frame8_row15", 32'(col_data), 32'h0002);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
